// File: rtl/xg_mac_rx_frame_fifo_if.sv
// AXI-Stream bundle used on both sides of the rx frame FIFO.
//   tdata  : 64-bit beat payload
//   tkeep  : byte enables, contiguous from bit 0
//   tvalid : beat valid
//   tready : sink accept (unused by the MAC side, which cannot stall)
//   tuser  : frame error flag, meaningful on the tlast beat only
//   tlast  : last beat of frame
// master drives the payload, slave drives tready.
interface xg_mac_rx_frame_fifo_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tkeep, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/xg_mac_rx_frame_fifo.sv
// Store-and-forward frame buffer behind the 10G MAC receive path.
// Frames are written as they arrive and only become visible to the reader
// once their last beat is stored without error. Errored frames and frames
// that do not fit are rewound to the last commit point and counted.
// Ports:
//   clock, reset   : rx clock, synchronous active-high reset
//   s_axis (slave) : MAC receive stream, no backpressure (tready tied high)
//   m_axis (master): complete good frames, backpressured by m_axis.tready
//   drop_error     : one-cycle pulse, frame discarded because tuser=1
//   drop_overflow  : one-cycle pulse, frame discarded for lack of space
//   frames_dropped : saturating count of all discarded frames
module xg_mac_rx_frame_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  xg_mac_rx_frame_fifo_if.slave  s_axis,
  xg_mac_rx_frame_fifo_if.master m_axis,
  output logic                  drop_error,
  output logic                  drop_overflow,
  output logic [31:0]           frames_dropped
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = 73;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [0:0] ST_STORE = 1'b0;
  localparam logic [0:0] ST_DROP  = 1'b1;

  // Each entry is {tlast, tkeep, tdata}.
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] wr_commit_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [0:0]    state_reg;
  logic          drop_error_reg;
  logic          drop_overflow_reg;
  logic [31:0]   frames_dropped_reg;
  logic [EW-1:0] out_data_reg;
  logic          out_valid_reg;

  logic full;
  logic avail;
  logic wr_en;
  logic load_out;

  // Occupancy counts every written entry, committed or not, so a frame in
  // progress cannot overwrite data the reader still owns.
  assign full  = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
  // Only committed entries are eligible for reading.
  assign avail = rd_ptr_reg != wr_commit_reg;
  assign wr_en = (state_reg == ST_STORE) && s_axis.tvalid && !full;
  // The output register is refilled straight from memory whenever it is
  // empty or its current beat is being taken, giving one beat per cycle.
  assign load_out = avail && (!out_valid_reg || m_axis.tready);

  // Storage and registered read, kept free of reset so it maps to block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
    if (load_out) begin
      out_data_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
    end
  end

  // Write side: store, commit or rewind.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg        <= '0;
      wr_commit_reg     <= '0;
      state_reg         <= ST_STORE;
      drop_error_reg    <= 1'b0;
      drop_overflow_reg <= 1'b0;
    end else begin
      drop_error_reg    <= 1'b0;
      drop_overflow_reg <= 1'b0;
      case (state_reg)
        ST_STORE: begin
          if (s_axis.tvalid) begin
            if (!full) begin
              wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
              if (s_axis.tlast) begin
                if (s_axis.tuser) begin
                  wr_ptr_reg     <= wr_commit_reg;
                  drop_error_reg <= 1'b1;
                end else begin
                  wr_commit_reg <= wr_ptr_reg + PTR_ONE;
                end
              end
            end else if (s_axis.tlast) begin
              // Frame ran out of space exactly on its last beat.
              wr_ptr_reg        <= wr_commit_reg;
              drop_overflow_reg <= 1'b1;
            end else begin
              state_reg <= ST_DROP;
            end
          end
        end
        default: begin
          // Swallow the rest of an overflowed frame; its tuser is irrelevant.
          if (s_axis.tvalid && s_axis.tlast) begin
            wr_ptr_reg        <= wr_commit_reg;
            drop_overflow_reg <= 1'b1;
            state_reg         <= ST_STORE;
          end
        end
      endcase
    end
  end

  // Read side control.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (load_out) begin
      rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
      out_valid_reg <= 1'b1;
    end else if (m_axis.tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Drop counter follows the registered pulses and saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      frames_dropped_reg <= '0;
    end else if ((drop_error_reg || drop_overflow_reg) &&
                 (frames_dropped_reg != 32'hFFFF_FFFF)) begin
      frames_dropped_reg <= frames_dropped_reg + 32'd1;
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tuser  = 1'b0;
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_data_reg;

  assign drop_error     = drop_error_reg;
  assign drop_overflow  = drop_overflow_reg;
  assign frames_dropped = frames_dropped_reg;

endmodule

// File: doc/xg_mac_rx_frame_fifo.md
Name: xg_mac_rx_frame_fifo

Overview:
- Store-and-forward frame buffer directly downstream of the 10G MAC receive path, in the rx clock domain.
- Accepts the MAC's receive AXI-Stream, which has no backpressure.
- Discards frames flagged bad (tuser=1 on the last beat) and frames that do not fit.
- Presents only complete, good frames on a backpressurable AXI-Stream master.

Parameters:
DEPTH_LOG2, 9, log2 of storage depth in 64-bit beats (512 beats = 4096 bytes); a frame longer than 2^DEPTH_LOG2 beats is always dropped.

Ports:
clock  input  1  rx clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_axis_tdata  input  64  receive data from MAC
s_axis_tvalid  input  1  beat valid; no tready, every valid beat must be consumed
s_axis_tkeep  input  8  byte enables, contiguous from bit 0
s_axis_tuser  input  1  qualified on tlast; 1 = errored frame
s_axis_tlast  input  1  last beat of frame
m_axis_tdata  output  64  buffered frame data
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream accept
m_axis_tkeep  output  8  byte enables of stored beat
m_axis_tlast  output  1  last beat of frame
drop_error  output  1  one-cycle pulse: frame discarded for tuser=1
drop_overflow  output  1  one-cycle pulse: frame discarded for lack of space
frames_dropped  output  32  saturating count of all discarded frames

Behaviour:
- Reset: all pointers = 0, write FSM = STORE, m_axis_tvalid = 0, drop_error = drop_overflow = 0, frames_dropped = 0. Stored and in-progress frames are discarded. Reset mid-frame: remaining beats of that frame are treated as a new frame.
- Storage: 2^DEPTH_LOG2 entries of {tlast, tkeep, tdata}, 73 bits each.
- Pointers: wr_ptr, wr_commit, rd_ptr are DEPTH_LOG2+1 bits wide. The extra bit is a wrap flag.
  - Full: wr_ptr - rd_ptr == 2^DEPTH_LOG2.
  - Frame available: rd_ptr != wr_commit.
- Write FSM:
  - STORE, valid beat, not full: write the entry at wr_ptr, wr_ptr++.
    - If tlast and tuser=0: wr_commit <= wr_ptr+1 (the pointer including this beat).
    - If tlast and tuser=1: wr_ptr <= wr_commit, pulse drop_error.
  - STORE, valid beat, full: beat not written. If tlast: wr_ptr <= wr_commit, pulse drop_overflow, stay STORE. Otherwise: go to DROP.
  - DROP: discard every valid beat. On tlast: wr_ptr <= wr_commit, pulse drop_overflow, go to STORE. tuser is ignored, so the frame counts as overflow only.
- Full is evaluated on register values at the start of the cycle. A read in the same cycle does not free space for the current write.
- Drop pulses are registered and assert in the cycle after the tlast beat. frames_dropped increments on each pulse and holds at 0xFFFFFFFF.
- Read side: synchronous memory read with a one-entry output register.
  - Output beat holds stable while m_axis_tvalid=1 and m_axis_tready=0.
  - The next entry is prefetched so that back-to-back beats sustain 1 beat/cycle when tready=1.
- Latency, empty FIFO and idle output: last good beat accepted in cycle N → wr_commit updated in cycle N+1 → first beat of the frame has m_axis_tvalid=1 in cycle N+2.
- Frames are output in arrival order. Beats are never output past wr_commit, so partial frames are never visible.
- Pointer wrap at 2^DEPTH_LOG2 is seamless. Frames may straddle the wrap.

Test Plan:
- Single good 8-beat frame (tkeep last = 0x0F), m_axis_tready=1 → identical 8 beats out; first tvalid 2 cycles after input tlast; no drop pulses.
- Good frame, then a 5-beat frame with tuser=1, then a good frame → only the two good frames out; drop_error pulses once; frames_dropped=1.
- DEPTH_LOG2=4, m_axis_tready=0, 12-beat good frame then 8-beat frame → first frame retained; second frame hits full and is dropped; drop_overflow pulses once; after tready=1, only the 12-beat frame appears.
- DEPTH_LOG2=4, 20-beat frame into an empty FIFO → dropped via DROP state; FIFO remains empty; frames_dropped=1.
- 200 random-length good frames with random m_axis_tready (50%) → output equals input stream; pointer wrap exercised; no output beat changes while stalled.
- Reset asserted for 1 cycle in beat 3 of a stored frame, with one committed frame unread → m_axis_tvalid=0 next cycle; counters=0; the following complete frame passes through intact.
